// File: rtl/montre_oci_pkg.sv
// Shared types and constants for the OCI debug-capture-trace (DCT) sequencer.
package montre_oci_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned FRAMES  = 3;
    localparam int unsigned BUF_W   = FRAME_W * FRAMES;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ADDR_W  = 7;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        ENDED   = 2'd2
    } dct_state_e;

endpackage

// File: rtl/montre_oci_dct_packer.sv
// Slot-insert trace buffer: packs FRAMES frames of FRAME_W bits into one trace word.
module montre_oci_dct_packer
    import montre_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               insert,
    input  logic [FRAME_W-1:0] frame,
    output logic [BUF_W-1:0]   buffer,
    output logic [CNT_W-1:0]   count,
    output logic               fill
);

    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    assign full   = (count_q == CNT_W'(FRAMES));
    // High when this insert lands in the final slot and completes the word.
    assign fill   = insert && !full && (count_q == CNT_W'(FRAMES - 1));
    assign buffer = buffer_q;
    assign count  = count_q;

    always_comb begin
        buffer_d = buffer_q;
        count_d  = count_q;
        if (clear) begin
            buffer_d = '0;
            count_d  = '0;
        end else if (insert && !full) begin
            for (int k = 0; k < FRAMES; k++) begin
                if (count_q == CNT_W'(k)) begin
                    buffer_d[k*FRAME_W +: FRAME_W] = frame;
                end
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/montre_nios2_qsys_0_oci_dct_ctrl.sv
// DCT sequencer: collects trace frames into words, writes them to trace RAM, flushes on test end.
module montre_nios2_qsys_0_oci_dct_ctrl
    import montre_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               test_ending,
    output logic [BUF_W-1:0]   tw_data,
    output logic [ADDR_W-1:0]  tw_addr,
    output logic               tw_write,
    input  logic               tw_waitrequest,
    output logic               tw_last,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               trace_wrap,
    output logic               test_has_ended
);

    dct_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic              wrap_q;
    logic              last_q;
    logic              end_req_q;

    logic              accept;
    logic              flush;
    logic              write_done;
    logic              fill;
    logic [CNT_W-1:0]  count;
    logic [BUF_W-1:0]  buffer;

    assign frame_ready    = (state == COLLECT);
    assign tw_write       = (state == WRITE);
    assign test_has_ended = (state == ENDED);
    assign accept         = frame_valid && frame_ready;
    // A request seen this cycle counts immediately, not only once latched.
    assign flush          = end_req_q || test_ending;
    assign write_done     = (state == WRITE) && !tw_waitrequest;

    montre_oci_dct_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (write_done),
        .insert  (accept),
        .frame   (frame_data),
        .buffer  (buffer),
        .count   (count),
        .fill    (fill)
    );

    assign dct_buffer = buffer;
    assign tw_data    = buffer;
    assign dct_count  = count;
    assign tw_addr    = addr_q;
    assign tw_last    = last_q;
    assign trace_wrap = wrap_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= COLLECT;
            addr_q    <= '0;
            wrap_q    <= 1'b0;
            last_q    <= 1'b0;
            end_req_q <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (test_ending) end_req_q <= 1'b1;
                    if (fill) begin
                        state  <= WRITE;
                        last_q <= flush;
                    end else if (flush) begin
                        // Flush sees the count after this cycle's accepted frame.
                        if ((count != '0) || accept) begin
                            state  <= WRITE;
                            last_q <= 1'b1;
                        end else begin
                            state <= ENDED;
                        end
                    end
                end
                WRITE: begin
                    if (test_ending) end_req_q <= 1'b1;
                    if (!tw_waitrequest) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (addr_q == '1) wrap_q <= 1'b1;
                        last_q <= 1'b0;
                        state  <= last_q ? ENDED : COLLECT;
                    end
                end
                ENDED: begin
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_montre_nios2_qsys_0_oci_dct_ctrl.sv
// Self-checking bench: transaction-level model of the DCT sequencer plus directed literal checks.
module tb_montre_nios2_qsys_0_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        test_ending;
    logic [29:0] tw_data;
    logic [6:0]  tw_addr;
    logic        tw_write;
    logic        tw_waitrequest;
    logic        tw_last;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        trace_wrap;
    logic        test_has_ended;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    montre_nios2_qsys_0_oci_dct_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .test_ending    (test_ending),
        .tw_data        (tw_data),
        .tw_addr        (tw_addr),
        .tw_write       (tw_write),
        .tw_waitrequest (tw_waitrequest),
        .tw_last        (tw_last),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .trace_wrap     (trace_wrap),
        .test_has_ended (test_has_ended)
    );

    // Model: frames held, whether a word is being written, words written so far.
    logic [9:0] m_frames[$];
    bit         m_writing;
    bit         m_last;
    bit         m_ended;
    bit         m_end_req;
    int         m_words;
    bit         started = 1'b0;

    function automatic logic [29:0] pack(input logic [9:0] q[$]);
        logic [29:0] w = '0;
        for (int k = 0; k < q.size(); k++) w = w | (30'(q[k]) << (10 * k));
        return w;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!reset_n) begin
            m_frames.delete();
            m_writing = 0; m_last = 0; m_ended = 0; m_end_req = 0; m_words = 0;
        end else if (m_ended) begin
        end else if (m_writing) begin
            if (test_ending) m_end_req = 1;
            if (!tw_waitrequest) begin
                m_words++;
                m_frames.delete();
                m_writing = 0;
                if (m_last) m_ended = 1;
                m_last = 0;
            end
        end else begin
            bit en;
            en = m_end_req || test_ending;
            if (test_ending) m_end_req = 1;
            if (frame_valid) m_frames.push_back(frame_data);
            if (m_frames.size() == 3) begin
                m_writing = 1; m_last = en;
            end else if (en) begin
                if (m_frames.size() > 0) begin
                    m_writing = 1; m_last = 1;
                end else begin
                    m_ended = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("frame_ready", 32'(frame_ready), 32'(!m_writing && !m_ended));
            check("tw_write", 32'(tw_write), 32'(m_writing));
            check("tw_last", 32'(tw_last), 32'(m_writing && m_last));
            check("dct_count", 32'(dct_count), 32'(m_frames.size()));
            check("dct_buffer", 32'(dct_buffer), 32'(pack(m_frames)));
            check("tw_data", 32'(tw_data), 32'(pack(m_frames)));
            check("tw_addr", 32'(tw_addr), 32'(m_words % 128));
            check("trace_wrap", 32'(trace_wrap), 32'(m_words >= 128));
            check("test_has_ended", 32'(test_has_ended), 32'(m_ended));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; frame_valid = 0; test_ending = 0; tw_waitrequest = 0; frame_data = '0;
        cyc(); cyc();
        reset_n = 1;
    endtask

    task automatic send3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        frame_valid = 1; frame_data = a; cyc();
        frame_data = b; cyc();
        frame_data = c; cyc();
        frame_valid = 0;
    endtask

    initial begin
        int guard;
        reset_n = 0; frame_valid = 0; test_ending = 0; tw_waitrequest = 0; frame_data = '0;
        cyc(); cyc();
        check("rst frame_ready", 32'(frame_ready), 32'd1);
        check("rst tw_write", 32'(tw_write), 32'd0);
        check("rst dct_count", 32'(dct_count), 32'd0);
        reset_n = 1;

        // 1: back-to-back, zero wait
        send3(10'h001, 10'h002, 10'h003);
        check("t1 tw_write", 32'(tw_write), 32'd1);
        check("t1 tw_data", 32'(tw_data), 32'h00300801);
        check("t1 tw_addr", 32'(tw_addr), 32'd0);
        check("t1 tw_last", 32'(tw_last), 32'd0);
        check("t1 frame_ready", 32'(frame_ready), 32'd0);
        cyc();
        check("t1 ready again", 32'(frame_ready), 32'd1);
        check("t1 count", 32'(dct_count), 32'd0);
        check("t1 addr", 32'(tw_addr), 32'd1);

        // 2: three stall cycles, source holds a frame
        tw_waitrequest = 1;
        send3(10'h001, 10'h002, 10'h003);
        frame_valid = 1; frame_data = 10'h0AA;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) tw_waitrequest = 0;
            check("t2 tw_write", 32'(tw_write), 32'd1);
            check("t2 tw_data", 32'(tw_data), 32'h00300801);
            check("t2 tw_addr", 32'(tw_addr), 32'd1);
            check("t2 frame_ready", 32'(frame_ready), 32'd0);
            cyc();
        end
        check("t2 done", 32'(tw_write), 32'd0);
        frame_valid = 0;
        do_reset();

        // 3: partial word flushed by test_ending pulse
        frame_valid = 1; frame_data = 10'h3FF; cyc();
        frame_data = 10'h155; cyc();
        frame_valid = 0; test_ending = 1; cyc();
        test_ending = 0;
        check("t3 tw_write", 32'(tw_write), 32'd1);
        check("t3 tw_data", 32'(tw_data), 32'h000557FF);
        check("t3 tw_last", 32'(tw_last), 32'd1);
        check("t3 count", 32'(dct_count), 32'd2);
        frame_valid = 1; frame_data = 10'h111; cyc();
        check("t3 ended", 32'(test_has_ended), 32'd1);
        cyc();
        check("t3 no accept", 32'(dct_count), 32'd0);
        check("t3 not ready", 32'(frame_ready), 32'd0);
        frame_valid = 0;
        do_reset();

        // 4: flush with empty buffer
        test_ending = 1; cyc();
        test_ending = 0;
        check("t4 no write", 32'(tw_write), 32'd0);
        check("t4 ended", 32'(test_has_ended), 32'd1);
        do_reset();

        // 5: 129 words wrap the address
        frame_valid = 1;
        guard = 0;
        while (m_words < 129 && guard < 2000) begin
            frame_data = 10'($urandom);
            cyc();
            guard++;
        end
        frame_valid = 0;
        check("t5 bound", 32'(guard < 2000), 32'd1);
        check("t5 wrap", 32'(trace_wrap), 32'd1);
        check("t5 addr", 32'(tw_addr), 32'd1);
        do_reset();

        // 6: reset during stalled write
        tw_waitrequest = 1;
        send3(10'h00A, 10'h00B, 10'h00C);
        cyc();
        check("t6 stalled", 32'(tw_write), 32'd1);
        reset_n = 0; cyc();
        reset_n = 1;
        check("t6 tw_write", 32'(tw_write), 32'd0);
        check("t6 count", 32'(dct_count), 32'd0);
        check("t6 addr", 32'(tw_addr), 32'd0);
        check("t6 ready", 32'(frame_ready), 32'd1);
        tw_waitrequest = 0;
        send3(10'h007, 10'h008, 10'h009);
        check("t6 rewrite addr", 32'(tw_addr), 32'd0);
        check("t6 rewrite data", 32'(tw_data), 32'h00902007);
        cyc();

        // Random traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                frame_valid    = ($urandom % 4) != 0;
                frame_data     = 10'($urandom);
                tw_waitrequest = ($urandom % 3) == 0;
                test_ending    = ($urandom % 97) == 0;
                reset_n        = ($urandom % 300) != 0;
                cyc();
            end
        end
        reset_n = 1; frame_valid = 0; test_ending = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
